reboot_request_ctrl: RTL

REBOOT_REQUEST_CTRL -- requirements
Module: reboot_request_ctrl

---
 rtl/reboot_request_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/reboot_request_ctrl.sv
// Reboot request controller: debounces the image-select switches, guards
// the reboot command behind a two-write unlock sequence with an idle
// timeout, and hands a stable image number to the ICAP sequencer.
module reboot_request_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  STARTUP_CYCLES  = 8'd16,
  parameter logic [7:0]  KEY_TIMEOUT     = 8'd255
) (
  input  logic       fastclk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ack,
  output logic       req,
  output logic [3:0] image_sel,
  output logic       armed,
  output logic [3:0] sw_stable
);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_KEY1,
    ST_ARMED,
    ST_REQ,
    ST_DONE
  } state_e;

  localparam logic [7:0] KEY_UNLOCK1 = 8'hA5;
  localparam logic [7:0] KEY_UNLOCK2 = 8'h5A;
  localparam logic [7:0] CMD_USE_SW  = 8'hFF;
  localparam logic [3:0] CMD_IMAGE   = 4'hB;

  state_e      state_q, state_d;
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]  sw_stable_q, sw_stable_d;
  logic [7:0]  startup_cnt_q, startup_cnt_d;
  logic [7:0]  timeout_cnt_q, timeout_cnt_d;
  logic [3:0]  image_sel_q, image_sel_d;
  logic        req_q, req_d;
  logic        armed_q, armed_d;

  // Two-flop synchronizer for the asynchronous switches.
  always_comb begin
    sync1_d = sw;
    sync2_d = sync1_q;
  end

  // Debounce: the counter advances only while the synchronized value
  // disagrees with the accepted one, so any return to the accepted value
  // restarts the qualification window.
  always_comb begin
    sw_stable_d = sw_stable_q;
    deb_cnt_d   = '0;
    if (sync2_q != sw_stable_q) begin
      if (deb_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        sw_stable_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 16'd1;
      end
    end
  end

  // Next-state logic; a write always wins over an expiring timeout.
  always_comb begin
    state_d       = state_q;
    startup_cnt_d = '0;
    timeout_cnt_d = '0;
    image_sel_d   = image_sel_q;
    case (state_q)
      ST_STARTUP: begin
        if (startup_cnt_q == STARTUP_CYCLES - 8'd1) begin
          state_d = ST_IDLE;
        end else begin
          startup_cnt_d = startup_cnt_q + 8'd1;
        end
      end
      ST_IDLE: begin
        if (wr_en && (wr_data == KEY_UNLOCK1)) begin
          state_d = ST_KEY1;
        end
      end
      ST_KEY1: begin
        if (wr_en) begin
          state_d = (wr_data == KEY_UNLOCK2) ? ST_ARMED : ST_IDLE;
        end else if (timeout_cnt_q == KEY_TIMEOUT - 8'd1) begin
          state_d = ST_IDLE;
        end else begin
          timeout_cnt_d = timeout_cnt_q + 8'd1;
        end
      end
      ST_ARMED: begin
        if (wr_en) begin
          if (wr_data[7:4] == CMD_IMAGE) begin
            image_sel_d = wr_data[3:0];
            state_d     = ST_REQ;
          end else if (wr_data == CMD_USE_SW) begin
            image_sel_d = sw_stable_q;
            state_d     = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timeout_cnt_q == KEY_TIMEOUT - 8'd1) begin
          state_d = ST_IDLE;
        end else begin
          timeout_cnt_d = timeout_cnt_q + 8'd1;
        end
      end
      ST_REQ: begin
        if (ack) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_STARTUP;
      end
    endcase
    // Outputs are decoded from the next state and registered, so req and
    // armed track the state register without an input-to-output path.
    req_d   = (state_d == ST_REQ);
    armed_d = (state_d == ST_ARMED);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      state_q       <= ST_STARTUP;
      sync1_q       <= '0;
      sync2_q       <= '0;
      deb_cnt_q     <= '0;
      sw_stable_q   <= '0;
      startup_cnt_q <= '0;
      timeout_cnt_q <= '0;
      image_sel_q   <= '0;
      req_q         <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_cnt_q     <= deb_cnt_d;
      sw_stable_q   <= sw_stable_d;
      startup_cnt_q <= startup_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      image_sel_q   <= image_sel_d;
      req_q         <= req_d;
      armed_q       <= armed_d;
    end
  end

  assign req       = req_q;
  assign armed     = armed_q;
  assign image_sel = image_sel_q;
  assign sw_stable = sw_stable_q;

endmodule
